// File: rtl/sc_pkg.sv
// sc_pkg: shared encodings for the fetch/PC sequencing stage.
//   - FSM state encoding
//   - pcsource selector values driven by the control unit
//   - trap cause codes
package sc_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_TRAP  = 2'd3;

    localparam logic [1:0] PCSRC_SEQ = 2'd0;
    localparam logic [1:0] PCSRC_BR  = 2'd1;
    localparam logic [1:0] PCSRC_REG = 2'd2;
    localparam logic [1:0] PCSRC_JMP = 2'd3;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_TIMEOUT = 2'b01;
    localparam logic [1:0] TRAP_ALIGN   = 2'b10;

endpackage

// File: rtl/sc_next_pc.sv
// sc_next_pc: combinational next-PC selection.
// Ports:
//   pc4       in  32  current pc + 4
//   inst      in  32  current instruction word
//   ra        in  32  register operand for jr
//   pcsource  in  2   selector from the control unit
//   next_pc   out 32  selected next program counter
//   misaligned out 1  next_pc is not word aligned
module sc_next_pc
    import sc_pkg::*;
(
    input  logic [31:0] pc4,
    input  logic [31:0] inst,
    input  logic [31:0] ra,
    input  logic [1:0]  pcsource,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] br_offset;
    logic        unused_opcode;

    // Opcode field is decoded downstream, not needed for target generation.
    assign unused_opcode = ^inst[31:26];

    assign br_offset = {{14{inst[15]}}, inst[15:0], 2'b00};

    always_comb begin
        next_pc = pc4;
        case (pcsource)
            PCSRC_SEQ: next_pc = pc4;
            PCSRC_BR:  next_pc = pc4 + br_offset;
            PCSRC_REG: next_pc = ra;
            PCSRC_JMP: next_pc = {pc4[31:28], inst[25:0], 2'b00};
            default:   next_pc = pc4;
        endcase
    end

    assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/sc_fetch_unit.sv
// sc_fetch_unit: instruction fetch and PC sequencing stage.
// Owns the PC, fetches from an instruction memory with a req/ack handshake
// (wait states allowed), presents each instruction for one commit cycle and
// traps on fetch timeout or a misaligned next PC.
// Ports:
//   clock, reset        rising-edge clock, async active-high reset
//   pcsource, ra        next-PC select and jr register operand
//   imem_ack/imem_rdata memory response
//   imem_req/imem_addr  memory request (registered), address = pc
//   pc, pc4             current pc and pc + 4
//   inst, inst_valid    held instruction word and commit strobe
//   trap, trap_cause, trap_pc  sticky fault status
//
// state   | meaning
// S_IDLE  | one cycle after reset release
// S_FETCH | request outstanding, waiting for imem_ack, timeout counting
// S_EXEC  | commit cycle, inst_valid high, pc advances on closing edge
// S_TRAP  | terminal fault, left only by reset
module sc_fetch_unit
    import sc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  pcsource,
    input  logic [31:0] ra,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [31:0] trap_pc
);

    localparam logic [7:0] COUNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [7:0]  count;
    logic [31:0] next_pc;
    logic        misaligned;

    assign pc4       = pc + 32'd4;
    assign imem_addr = pc;

    sc_next_pc u_next_pc (
        .pc4        (pc4),
        .inst       (inst),
        .ra         (ra),
        .pcsource   (pcsource),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

    // imem_req and inst_valid are registered alongside the state so they
    // are glitch-free decodes of the state the FSM is entering.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            inst       <= 32'd0;
            imem_req   <= 1'b0;
            inst_valid <= 1'b0;
            trap       <= 1'b0;
            trap_cause <= TRAP_NONE;
            trap_pc    <= 32'd0;
            count      <= 8'd0;
        end else begin
            inst_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                    count    <= 8'd0;
                end
                S_FETCH: begin
                    // ack has priority over an expiring timeout
                    if (imem_ack) begin
                        inst       <= imem_rdata;
                        count      <= 8'd0;
                        state      <= S_EXEC;
                        imem_req   <= 1'b0;
                        inst_valid <= 1'b1;
                    end else if (count == COUNT_LAST) begin
                        state      <= S_TRAP;
                        imem_req   <= 1'b0;
                        trap       <= 1'b1;
                        trap_cause <= TRAP_TIMEOUT;
                        trap_pc    <= pc;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                S_EXEC: begin
                    if (!misaligned) begin
                        pc       <= next_pc;
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                    end else begin
                        state      <= S_TRAP;
                        trap       <= 1'b1;
                        trap_cause <= TRAP_ALIGN;
                        trap_pc    <= pc;
                    end
                end
                S_TRAP: begin
                    imem_req <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sc_fetch_unit.sv
// Directed self-checking bench for sc_fetch_unit.
module tb_sc_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  pcsource;
    logic [31:0] ra;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic        inst_valid;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [31:0] trap_pc;

    int checks = 0;
    int errors = 0;

    sc_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(15)) dut (
        .clock      (clock),
        .reset      (reset),
        .pcsource   (pcsource),
        .ra         (ra),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .pc         (pc),
        .pc4        (pc4),
        .inst       (inst),
        .inst_valid (inst_valid),
        .trap       (trap),
        .trap_cause (trap_cause),
        .trap_pc    (trap_pc)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Called just after an edge with reset high; releases it so that the
    // following full cycle is the idle cycle.
    task automatic release_reset();
        reset = 1'b0;
        chk("idle_req", 32'(imem_req), 32'd0);
        tick();
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, 32'h0);
    endtask

    // Runs one instruction from its first FETCH cycle through EXEC.
    task automatic run_instr(input string tag, input int waits, input logic [31:0] word,
                             input logic [1:0] psrc, input logic [31:0] rav,
                             input logic [31:0] exp_pc, input logic [31:0] exp_next);
        chk({tag, "_addr"}, imem_addr, exp_pc);
        for (int i = 0; i <= waits; i++) begin
            chk({tag, "_req"}, 32'(imem_req), 32'd1);
            chk({tag, "_nvalid"}, 32'(inst_valid), 32'd0);
            imem_ack   = (i == waits);
            imem_rdata = (i == waits) ? word : 32'hDEAD_BEEF;
            tick();
        end
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        pcsource   = psrc;
        ra         = rav;
        chk({tag, "_valid"}, 32'(inst_valid), 32'd1);
        chk({tag, "_inst"}, inst, word);
        chk({tag, "_pc"}, pc, exp_pc);
        chk({tag, "_pc4"}, pc4, exp_pc + 32'd4);
        chk({tag, "_exreq"}, 32'(imem_req), 32'd0);
        tick();
        chk({tag, "_next"}, pc, exp_next);
        chk({tag, "_valid_off"}, 32'(inst_valid), 32'd0);
    endtask

    initial begin
        int n;
        reset      = 1'b1;
        pcsource   = 2'd0;
        ra         = 32'd0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;

        // Reset values
        tick();
        tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_trap", 32'(trap), 32'd0);
        chk("rst_inst", inst, 32'h0);

        // Reset asserted asynchronously mid-wait
        release_reset();
        for (int i = 0; i < 4; i++) tick();
        chk("wait_req", 32'(imem_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_req", 32'(imem_req), 32'd0);
        chk("async_pc", pc, 32'h0);
        chk("async_trap", 32'(trap), 32'd0);
        tick();

        // Late ack during IDLE is ignored, then timeout with ack held low
        reset      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        tick();
        imem_ack = 1'b0;
        chk("late_ack_inst", inst, 32'h0);
        chk("late_ack_valid", 32'(inst_valid), 32'd0);
        chk("late_ack_req", 32'(imem_req), 32'd1);
        n = 0;
        while (imem_req && n < 40) begin
            tick();
            n++;
        end
        chk("timeout_cycles", 32'(n), 32'd15);
        chk("timeout_trap", 32'(trap), 32'd1);
        chk("timeout_cause", 32'(trap_cause), 32'b01);
        chk("timeout_trap_pc", trap_pc, 32'h0);

        // Reset out of the trap state clears it asynchronously
        #2 reset = 1'b1;
        #1;
        chk("trap_clear", 32'(trap), 32'd0);
        chk("cause_clear", 32'(trap_cause), 32'd0);
        tick();
        release_reset();

        // Main instruction sequence
        run_instr("seq0", 0, 32'h2008_0005, 2'd0, 32'd0, 32'h0, 32'h4);
        run_instr("seq1", 0, 32'h2008_0005, 2'd0, 32'd0, 32'h4, 32'h8);
        run_instr("seq2", 0, 32'h2008_0005, 2'd0, 32'd0, 32'h8, 32'hC);
        run_instr("seq3", 0, 32'h2008_0005, 2'd0, 32'd0, 32'hC, 32'h10);
        run_instr("br_self", 3, 32'h1000_FFFF, 2'd1, 32'd0, 32'h10, 32'h10);
        run_instr("jr_far", 0, 32'h0000_0008, 2'd2, 32'h0040_0000, 32'h10, 32'h0040_0000);
        run_instr("jal", 0, 32'h0C00_0040, 2'd3, 32'd0, 32'h0040_0000, 32'h0000_0100);
        run_instr("jr_top", 0, 32'h0000_0008, 2'd2, 32'hFFFF_FFFC, 32'h100, 32'hFFFF_FFFC);
        run_instr("wrap", 0, 32'h2008_0005, 2'd0, 32'd0, 32'hFFFF_FFFC, 32'h0);
        chk("wrap_notrap", 32'(trap), 32'd0);
        run_instr("jr_20", 0, 32'h0000_0008, 2'd2, 32'h20, 32'h0, 32'h20);

        // Misaligned jr target
        run_instr("align", 0, 32'h0000_0008, 2'd2, 32'h102, 32'h20, 32'h20);
        chk("align_trap", 32'(trap), 32'd1);
        chk("align_cause", 32'(trap_cause), 32'b10);
        chk("align_trap_pc", trap_pc, 32'h20);
        imem_ack   = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("trap_noreq", 32'(imem_req), 32'd0);
            chk("trap_novalid", 32'(inst_valid), 32'd0);
        end
        imem_ack = 1'b0;
        chk("trap_inst_hold", inst, 32'h0000_0008);
        chk("trap_pc_hold", pc, 32'h20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
